// File: rtl/screen_scanner.sv
// Screen read-out stage: fetches the screen-mapped words from the data memory
// and streams them out one pixel per handshake, bit 0 of each word first.
module screen_scanner #(
   parameter logic [15:0] BASE_ADDR     = 16'h4000,
   parameter int          WORDS_PER_ROW = 32,
   parameter int          ROWS          = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_eof,
   output logic        frame_done,
   output logic        busy
);

   localparam logic [15:0] LAST_ADDR = 16'(int'(BASE_ADDR) + WORDS_PER_ROW * ROWS - 1);
   localparam logic [15:0] LAST_COL  = 16'(WORDS_PER_ROW - 1);
   localparam logic [15:0] LAST_ROW  = 16'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_r;
   logic [15:0] sh_data_r;
   logic [4:0]  sh_cnt_r;
   logic [15:0] pf_data_r;
   logic        pf_valid_r;
   logic        data_pend_r;
   logic        mem_rd_r;
   logic [15:0] mem_addr_r;
   logic [15:0] nxt_addr_r;
   logic [15:0] cur_col_r;
   logic [15:0] cur_row_r;
   logic        frame_done_r;

   logic        sh_empty_s;
   logic        valid_s;
   logic        xfer_s;
   logic        sh_last_s;
   logic [15:0] cur_word_s;
   logic [4:0]  bit_idx_s;
   logic        at_sof_s;
   logic        at_eol_s;
   logic        at_eof_s;
   logic        pf_free_s;
   logic        rd_ok_s;

   // Current-pixel view; an empty shifter shows the word arriving from memory this cycle.
   always_comb begin
      sh_empty_s = (sh_cnt_r == 5'd0);
      valid_s    = !sh_empty_s || data_pend_r;
      xfer_s     = valid_s && pix_ready;
      sh_last_s  = xfer_s && (sh_cnt_r == 5'd1);
      if (sh_empty_s) begin
         cur_word_s = mem_data;
         bit_idx_s  = 5'd0;
      end else begin
         cur_word_s = sh_data_r;
         bit_idx_s  = 5'd16 - sh_cnt_r;
      end
      at_sof_s  = valid_s && (cur_col_r == 16'd0) && (cur_row_r == 16'd0) && (bit_idx_s == 5'd0);
      at_eol_s  = valid_s && (cur_col_r == LAST_COL) && (bit_idx_s == 5'd15);
      at_eof_s  = at_eol_s && (cur_row_r == LAST_ROW);
      pf_free_s = !pf_valid_r || sh_last_s;
      rd_ok_s   = !mem_rd_r && !data_pend_r && pf_free_s;
   end

   // Shift register, prefetch slot and output position tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_data_r    <= 16'd0;
         sh_cnt_r     <= 5'd0;
         pf_data_r    <= 16'd0;
         pf_valid_r   <= 1'b0;
         data_pend_r  <= 1'b0;
         cur_col_r    <= 16'd0;
         cur_row_r    <= 16'd0;
         frame_done_r <= 1'b0;
      end else begin
         data_pend_r  <= mem_rd_r;
         frame_done_r <= xfer_s && at_eof_s;
         if (sh_last_s) begin
            if (pf_valid_r) begin
               sh_data_r  <= pf_data_r;
               sh_cnt_r   <= 5'd16;
               pf_valid_r <= 1'b0;
            end else if (data_pend_r) begin
               sh_data_r <= mem_data;
               sh_cnt_r  <= 5'd16;
            end else begin
               sh_cnt_r <= 5'd0;
            end
         end else if (sh_empty_s && data_pend_r) begin
            // First pixel of the fresh word may leave on the same edge it is captured.
            if (xfer_s) begin
               sh_data_r <= {1'b0, mem_data[15:1]};
               sh_cnt_r  <= 5'd15;
            end else begin
               sh_data_r <= mem_data;
               sh_cnt_r  <= 5'd16;
            end
         end else begin
            if (xfer_s) begin
               sh_data_r <= {1'b0, sh_data_r[15:1]};
               sh_cnt_r  <= sh_cnt_r - 5'd1;
            end
            if (data_pend_r) begin
               pf_data_r  <= mem_data;
               pf_valid_r <= 1'b1;
            end
         end
         if (sh_last_s) begin
            if (cur_col_r == LAST_COL) begin
               cur_col_r <= 16'd0;
               cur_row_r <= (cur_row_r == LAST_ROW) ? 16'd0 : cur_row_r + 16'd1;
            end else begin
               cur_col_r <= cur_col_r + 16'd1;
            end
         end
      end
   end

   // Frame sequencing and read issue; enable only matters in IDLE and at the last read of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         mem_rd_r   <= 1'b0;
         mem_addr_r <= BASE_ADDR;
         nxt_addr_r <= BASE_ADDR;
      end else begin
         mem_rd_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (enable) begin
                  state_r    <= RUN;
                  mem_rd_r   <= 1'b1;
                  mem_addr_r <= nxt_addr_r;
                  nxt_addr_r <= (nxt_addr_r == LAST_ADDR) ? BASE_ADDR : nxt_addr_r + 16'd1;
               end
            end
            RUN: begin
               if (rd_ok_s) begin
                  mem_rd_r   <= 1'b1;
                  mem_addr_r <= nxt_addr_r;
                  nxt_addr_r <= (nxt_addr_r == LAST_ADDR) ? BASE_ADDR : nxt_addr_r + 16'd1;
                  if ((nxt_addr_r == LAST_ADDR) && !enable) begin
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (xfer_s && at_eof_s) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr   = mem_addr_r;
   assign mem_rd     = mem_rd_r;
   assign pix_valid  = valid_s;
   assign pix        = valid_s & cur_word_s[0];
   assign pix_sof    = at_sof_s;
   assign pix_eol    = at_eol_s;
   assign pix_eof    = at_eof_s;
   assign frame_done = frame_done_r;
   assign busy       = (state_r != IDLE);

endmodule

// File: doc/screen_scanner.md
Name: screen_scanner

Overview:
- Display read-out stage directly downstream of the data memory; consumes the screen-mapped region (default 0x4000–0x5FFF, 512x256 monochrome).
- Issues word reads to the memory's read port and serialises each 16-bit word into a 1-bit pixel stream under a valid/ready handshake.
- Emits frame and line markers for the video back-end.
- Memory read is synchronous: data on mem_data is valid the cycle after mem_rd/mem_addr are presented.

Parameters:
- BASE_ADDR, 16'h4000, first word address of screen region.
- WORDS_PER_ROW, 32, 16-bit words per pixel row (512 px).
- ROWS, 256, rows per frame.
- Legal range: BASE_ADDR + WORDS_PER_ROW*ROWS <= 65536, both counts >= 1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; high requests frames.
- mem_addr  out  16  word address to memory read port.
- mem_rd  out  1  read strobe; mem_data valid next cycle.
- mem_data  in  16  read data from memory.
- pix_valid  out  1  pix and flags are valid.
- pix_ready  in  1  consumer accepts pixel this cycle.
- pix  out  1  pixel value (1 = black).
- pix_sof  out  1  first pixel of frame (x=0, y=0).
- pix_eol  out  1  last pixel of a row (x = 16*WORDS_PER_ROW-1).
- pix_eof  out  1  last pixel of frame.
- frame_done  out  1  one-cycle pulse when the eof pixel is accepted.
- busy  out  1  high while not IDLE.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: mem_addr=BASE_ADDR, mem_rd=0, pix_valid=0, pix=0, all flags=0, frame_done=0, busy=0, state IDLE, buffers empty, counters 0.
- Reset asserted mid-frame aborts immediately. No completion of the current word or frame.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on an edge with enable=1.
  - RUN -> DRAIN when the last word read of a frame is issued and enable=0 at that edge.
  - DRAIN -> IDLE when the eof pixel is accepted.
- Pixel order:
  - Word address = BASE_ADDR + row*WORDS_PER_ROW + col.
  - Within a word, bit 0 is emitted first (leftmost pixel), bit 15 last.
  - Pixel x = 16*col + bit.
- Buffering:
  - Shift register (current word, 16-pixel count) plus one prefetch register with a valid bit.
  - At most one read outstanding.
  - A read is issued when the prefetch register is empty, or will be emptied at this edge, and no read is outstanding.
  - Returned data goes to the shift register if empty, otherwise to prefetch.
- Latency:
  - enable sampled high in IDLE at edge k -> mem_rd=1, mem_addr=BASE_ADDR during cycle k+1.
  - pix_valid=1 with pixel (0,0) from cycle k+2.
- Throughput: with pix_ready held high, one pixel per cycle and no pix_valid gaps within a frame. Consecutive frames also have no gaps while enable stays high.
- Handshake:
  - Transfer when pix_valid && pix_ready.
  - While pix_valid && !pix_ready, pix and all flags hold stable and no shift occurs.
  - pix_valid never drops without a transfer, except on reset.
- Address wrap: after the word at BASE_ADDR+WORDS_PER_ROW*ROWS-1, the next read is BASE_ADDR if RUN continues. Row and col counters wrap together.
- Flags:
  - pix_sof, pix_eol and pix_eof are combinational qualifiers of the current pixel, valid only with pix_valid.
  - pix_eof implies pix_eol.
- enable deassertion mid-frame: current frame always completes, then IDLE. enable glitches are ignored until the frame boundary.
- frame_done: registered, high for exactly one cycle after the edge that accepts the eof pixel.
- mem_rd is high for exactly one cycle per word. mem_addr holds its last value when mem_rd=0.

Test Plan:
- Params WORDS_PER_ROW=2, ROWS=2, BASE_ADDR=16'h4000; memory model preloaded 0x4000=16'h0001, 0x4001=16'h8000, 0x4002=16'hFFFF, 0x4003=16'h0000; enable pulsed 1 cycle; pix_ready=1 -> 64 contiguous pixels:
  - px0=1 with sof, px1..30=0, px31=1 with eol, px32..47=1, px48..63=0;
  - px63 has eol+eof; frame_done pulses once; return to IDLE, busy=0.
- Same stimulus -> first mem_rd at cycle k+1 with addr 0x4000, first pix_valid at k+2; mem_rd asserted exactly 4 times with addresses 0x4000..0x4003.
- Random pix_ready (about 30% low) -> identical 64-pixel sequence; pix/flags stable during every stall; never more than one read outstanding.
- enable held high for 2 frames, ready=1 -> 128 pixels with no pix_valid gap; 5th read addr wraps to 0x4000; frame_done pulses twice, 64 cycles apart.
- Drop enable at pixel 10 -> frame completes through pixel 63, then IDLE; no further mem_rd.
- Assert rst_n=0 at pixel 20 -> same cycle, pix_valid=0, mem_rd=0, busy=0; after release with enable=1, stream restarts at 0x4000 with sof.
